// File: rtl/led_fade_pwm.sv
// rtl/led_fade_pwm.sv - multi-channel LED PWM engine with frame-aligned level updates and linear fade
module led_fade_pwm #(
   parameter int NCH      = 8,
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [7:0]     ui_in,
   input  logic [7:0]     reg_addr,
   input  logic           reg_wen,
   input  logic [7:0]     reg_wdata,
   output logic [7:0]     reg_rdata,
   output logic [NCH-1:0] pwm_out,
   output logic           frame_pulse
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] RAMP_LAST = WIDTH'((2 ** WIDTH) - 2);
   localparam logic [7:0] ADDR_CUR  = 8'h10;
   localparam logic [7:0] ADDR_CTRL = 8'h20;
   localparam logic [7:0] ADDR_RATE = 8'h21;
   localparam logic [7:0] ADDR_NCH  = 8'h22;
   localparam logic [7:0] ADDR_WID  = 8'h23;

   logic [PW-1:0]    presc_q;
   logic [WIDTH-1:0] ramp_q;
   logic [7:0]       frame_cnt_q;
   logic [7:0]       fade_rate_q;
   logic             host_mode_q;
   logic             fade_en_q;
   logic [WIDTH-1:0] target_q  [NCH];
   logic [WIDTH-1:0] current_q [NCH];

   logic tick;
   logic boundary;
   logic target_wr;
   logic fade_step;

   assign tick      = (presc_q == PW'(PRESCALE - 1));
   assign boundary  = tick && (ramp_q == RAMP_LAST);
   assign target_wr = reg_wen && (reg_addr < 8'(NCH));
   assign fade_step = (frame_cnt_q == fade_rate_q);

   // The ramp stops one short of full scale so level 2^WIDTH-1 stays high all frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= '0;
         ramp_q      <= '0;
         frame_pulse <= 1'b0;
      end else begin
         presc_q     <= tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            ramp_q <= (ramp_q == RAMP_LAST) ? '0 : ramp_q + WIDTH'(1);
         end
         frame_pulse <= boundary;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_mode_q <= 1'b0;
         fade_en_q   <= 1'b0;
         fade_rate_q <= 8'h00;
         frame_cnt_q <= 8'h00;
      end else begin
         if (target_wr) begin
            host_mode_q <= 1'b1;
         end else if (reg_wen && (reg_addr == ADDR_CTRL)) begin
            host_mode_q <= reg_wdata[0];
            fade_en_q   <= reg_wdata[1];
         end
         if (reg_wen && (reg_addr == ADDR_RATE)) begin
            fade_rate_q <= reg_wdata;
         end
         if (boundary && fade_en_q) begin
            frame_cnt_q <= fade_step ? 8'h00 : frame_cnt_q + 8'd1;
         end
      end
   end

   // CURRENT samples the registered TARGET, so a write in the boundary cycle lands one frame later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            target_q[i]  <= '0;
            current_q[i] <= '0;
         end
         pwm_out <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (target_wr) begin
               if (reg_addr == 8'(i)) begin
                  target_q[i] <= reg_wdata[WIDTH-1:0];
               end
            end else if (!host_mode_q) begin
               target_q[i] <= (ui_in == 8'h00) ? '0 : WIDTH'(ui_in ^ 8'(i << 4));
            end
            if (boundary) begin
               if (!fade_en_q) begin
                  current_q[i] <= target_q[i];
               end else if (fade_step) begin
                  if (current_q[i] < target_q[i]) begin
                     current_q[i] <= current_q[i] + WIDTH'(1);
                  end else if (current_q[i] > target_q[i]) begin
                     current_q[i] <= current_q[i] - WIDTH'(1);
                  end
               end
            end
            pwm_out[i] <= (current_q[i] > ramp_q);
         end
      end
   end

   always_comb begin
      reg_rdata = 8'h00;
      for (int i = 0; i < NCH; i++) begin
         if (reg_addr == 8'(i)) begin
            reg_rdata = 8'(target_q[i]);
         end
         if (reg_addr == ADDR_CUR + 8'(i)) begin
            reg_rdata = 8'(current_q[i]);
         end
      end
      case (reg_addr)
         ADDR_CTRL: reg_rdata = {6'b000000, fade_en_q, host_mode_q};
         ADDR_RATE: reg_rdata = fade_rate_q;
         ADDR_NCH:  reg_rdata = 8'(NCH);
         ADDR_WID:  reg_rdata = 8'(WIDTH);
         default:   ;
      endcase
   end

endmodule
